// File: rtl/tetris_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tetris_game_sequencer
// Purpose  : Game-phase controller for the 4-wide x 8-row Tetris board
//            datapath. It sequences NEWBOARD/GEN/MOVE/LAND/CLEAR/OVER,
//            picks each new piece from a free-running LFSR, paces gravity
//            with a level-dependent drop timer, counts cleared lines and
//            detects game over from the spawn-collision flag.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clka          in   1   clock, posedge
//   restart_n     in   1   asynchronous active-low reset
//   start_i       in   1   player start (level, sampled)
//   landed_i      in   1   active piece has landed
//   error_i       in   1   spawn collision
//   board_i       in  32   board, row r = bits [4r+3:4r]
//   state_o       out  3   phase: 0 GEN 1 MOVE 2 LAND 3 CLEAR 4 NEWBOARD 5 OVER
//   curr_piece_o  out  2   piece to spawn
//   drop_tick_o   out  1   one-cycle gravity pulse
//   game_over_o   out  1   high while in OVER
//   lines_o       out  8   cleared-line total, saturating at 255
//   level_o       out  3   min(lines_o/4, 7)
// ============================================================================
module tetris_game_sequencer #(
  parameter int         DROP_BASE = 16,
  parameter int         DROP_STEP = 2,
  parameter int         DROP_MIN  = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic        clka,
  input  logic        restart_n,
  input  logic        start_i,
  input  logic        landed_i,
  input  logic        error_i,
  input  logic [31:0] board_i,
  output logic [2:0]  state_o,
  output logic [1:0]  curr_piece_o,
  output logic        drop_tick_o,
  output logic        game_over_o,
  output logic [7:0]  lines_o,
  output logic [2:0]  level_o
);

  // Wide enough for whichever of the base or minimum period is larger.
  localparam int CNT_W = $clog2(DROP_BASE + DROP_MIN + 1);

  typedef enum logic [2:0] {
    ST_GEN      = 3'd0,
    ST_MOVE     = 3'd1,
    ST_LAND     = 3'd2,
    ST_CLEAR    = 3'd3,
    ST_NEWBOARD = 3'd4,
    ST_OVER     = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         dwell_q, dwell_d;
  logic [CNT_W-1:0]   grav_q, grav_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [1:0]         piece_q, piece_d;
  logic [7:0]         lines_q, lines_d;
  logic [2:0]         level_q, level_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               game_over_q, game_over_d;

  logic [3:0]         full_rows;
  logic [1:0]         full_capped;
  logic [8:0]         lines_sum;
  logic               grav_wrap;

  // Gravity period for a level, clamped to the minimum.
  function automatic logic [CNT_W-1:0] period_for(input logic [2:0] lvl);
    int p;
    p = DROP_BASE - int'(lvl) * DROP_STEP;
    if (p < DROP_MIN) p = DROP_MIN;
    return CNT_W'(p);
  endfunction

  // Count completely filled rows; at most two are credited per landing.
  always_comb begin
    full_rows = 4'd0;
    for (int r = 0; r < 8; r++) begin
      if (board_i[4*r +: 4] == 4'hF) full_rows = full_rows + 4'd1;
    end
    full_capped = (full_rows >= 4'd2) ? 2'd2 : full_rows[1:0];
    lines_sum   = {1'b0, lines_q} + {7'd0, full_capped};
  end

  assign grav_wrap = (grav_q == (period_q - CNT_W'(1)));

  always_comb begin
    state_d     = state_q;
    dwell_d     = 2'd0;
    grav_d      = '0;
    period_d    = period_q;
    piece_d     = piece_q;
    lines_d     = lines_q;
    level_d     = level_q;
    game_over_d = 1'b0;
    // Fibonacci LFSR, taps 8,6,5,4; runs every cycle so player timing
    // perturbs the piece sequence.
    lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    case (state_q)
      ST_NEWBOARD: if (dwell_q == 2'd2 && start_i) state_d = ST_GEN;
      ST_GEN:      if (dwell_q == 2'd1) state_d = error_i ? ST_OVER : ST_MOVE;
      ST_MOVE:     if (landed_i) state_d = ST_LAND;
      ST_LAND: begin
        lines_d = lines_sum[8] ? 8'hFF : lines_sum[7:0];
        state_d = ST_CLEAR;
      end
      ST_CLEAR:    if (dwell_q == 2'd1) state_d = ST_GEN;
      ST_OVER:     if (start_i) state_d = ST_NEWBOARD;
      default:     state_d = ST_NEWBOARD;
    endcase

    // Shared dwell counter: cleared on any state change, saturates at 2.
    if (state_d == state_q &&
        (state_q == ST_NEWBOARD || state_q == ST_GEN || state_q == ST_CLEAR)) begin
      dwell_d = (dwell_q == 2'd2) ? 2'd2 : dwell_q + 2'd1;
    end

    if (state_d == ST_GEN && state_q != ST_GEN) piece_d = lfsr_q[1:0];

    // Period is frozen at MOVE entry so a level-up mid-drop has no effect
    // until the next piece.
    if (state_d == ST_MOVE && state_q != ST_MOVE) period_d = period_for(level_q);

    if (state_d == ST_MOVE && state_q == ST_MOVE) grav_d = grav_wrap ? '0 : grav_q + CNT_W'(1);

    if (state_q == ST_OVER && state_d == ST_NEWBOARD) lines_d = 8'd0;

    level_d     = (lines_d >= 8'd28) ? 3'd7 : lines_d[4:2];
    game_over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q     <= ST_NEWBOARD;
      dwell_q     <= 2'd0;
      grav_q      <= '0;
      period_q    <= period_for(3'd0);
      piece_q     <= 2'd0;
      lines_q     <= 8'd0;
      level_q     <= 3'd0;
      lfsr_q      <= LFSR_SEED;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      grav_q      <= grav_d;
      period_q    <= period_d;
      piece_q     <= piece_d;
      lines_q     <= lines_d;
      level_q     <= level_d;
      lfsr_q      <= lfsr_d;
      game_over_q <= game_over_d;
    end
  end

  assign state_o      = state_q;
  assign curr_piece_o = piece_q;
  assign game_over_o  = game_over_q;
  assign lines_o      = lines_q;
  assign level_o      = level_q;
  // A landing in the same cycle suppresses the gravity pulse.
  assign drop_tick_o  = (state_q == ST_MOVE) && grav_wrap && !landed_i;

endmodule
`default_nettype wire

// File: tb/tb_tetris_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_game_sequencer
// Purpose  : Directed self-checking bench for tetris_game_sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_tetris_game_sequencer;

  logic        clka = 1'b0;
  logic        restart_n;
  logic        start_i;
  logic        landed_i;
  logic        error_i;
  logic [31:0] board_i;
  logic [2:0]  state_o;
  logic [1:0]  curr_piece_o;
  logic        drop_tick_o;
  logic        game_over_o;
  logic [7:0]  lines_o;
  logic [2:0]  level_o;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          exp_lines = 0;
  logic [7:0]  lfsr_m;
  logic [7:0]  lfsr_prev;

  tetris_game_sequencer dut (
    .clka         (clka),
    .restart_n    (restart_n),
    .start_i      (start_i),
    .landed_i     (landed_i),
    .error_i      (error_i),
    .board_i      (board_i),
    .state_o      (state_o),
    .curr_piece_o (curr_piece_o),
    .drop_tick_o  (drop_tick_o),
    .game_over_o  (game_over_o),
    .lines_o      (lines_o),
    .level_o      (level_o)
  );

  always #5 clka = ~clka;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int exp_level(input int l);
    return (l / 4 > 7) ? 7 : l / 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clka);
    lfsr_prev = lfsr_m;
    lfsr_m    = lfsr_next(lfsr_m);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state_o), 32'd4);
    chk({tag, "_piece"}, 32'(curr_piece_o), 32'd0);
    chk({tag, "_tick"},  32'(drop_tick_o), 32'd0);
    chk({tag, "_over"},  32'(game_over_o), 32'd0);
    chk({tag, "_lines"}, 32'(lines_o), 32'd0);
    chk({tag, "_level"}, 32'(level_o), 32'd0);
  endtask

  // NEWBOARD (dwell 0) -> GEN -> first MOVE cycle.
  task automatic start_game();
    start_i = 1'b1;
    step(); chk("nb_d1", 32'(state_o), 32'd4);
    step(); chk("nb_d2", 32'(state_o), 32'd4);
    step(); chk("gen1", 32'(state_o), 32'd0);
    chk("gen_piece", 32'(curr_piece_o), 32'(lfsr_prev[1:0]));
    start_i = 1'b0;
    step(); chk("gen2", 32'(state_o), 32'd0);
    step(); chk("move_entry", 32'(state_o), 32'd1);
  endtask

  // Observes MOVE cycles 1..n (cycle 1 is current); tick every p cycles.
  task automatic gravity(input int n, input int p);
    for (int i = 1; i <= n; i++) begin
      if (i > 1) step();
      chk($sformatf("tick_c%0d_p%0d", i, p), 32'(drop_tick_o), 32'((i % p) == 0));
    end
  endtask

  // Called in MOVE: land, clear, regenerate; e1/e2 = error_i in GEN cycles.
  task automatic land_cycle(input logic [31:0] b, input int add, input bit e1, input bit e2);
    landed_i = 1'b1;
    board_i  = b;
    #1;
    chk("tick_masked", 32'(drop_tick_o), 32'd0);
    step(); landed_i = 1'b0;
    chk("land", 32'(state_o), 32'd2);
    exp_lines = (exp_lines + add > 255) ? 255 : exp_lines + add;
    step(); chk("clear1", 32'(state_o), 32'd3);
    chk("lines", 32'(lines_o), 32'(exp_lines));
    chk("level", 32'(level_o), 32'(exp_level(exp_lines)));
    step(); chk("clear2", 32'(state_o), 32'd3);
    step(); chk("regen1", 32'(state_o), 32'd0);
    chk("regen_piece", 32'(curr_piece_o), 32'(lfsr_prev[1:0]));
    error_i = e1;
    step(); chk("regen2", 32'(state_o), 32'd0);
    error_i = e2;
    step(); error_i = 1'b0;
    chk("post_gen", 32'(state_o), e2 ? 32'd5 : 32'd1);
    chk("post_gen_over", 32'(game_over_o), 32'(e2));
  endtask

  initial begin
    restart_n = 1'b0;
    start_i   = 1'b1;
    landed_i  = 1'b0;
    error_i   = 1'b0;
    board_i   = 32'h0;
    lfsr_m    = 8'hA5;
    lfsr_prev = 8'hA5;
    #12;
    chk_reset_vals("reset");
    #11 restart_n = 1'b1;

    // Reset -> start with start_i held; seed A5 gives piece 1 on GEN entry.
    start_game();
    chk("first_piece_const", 32'(curr_piece_o), 32'd1);

    // Level-0 gravity: ticks on cycles 16 and 32 of MOVE.
    gravity(40, 16);

    // Three double clears -> 6 lines, level 1, next period 14.
    land_cycle(32'hFF00_0000, 2, 1'b0, 1'b0);
    land_cycle(32'hFF00_0000, 2, 1'b0, 1'b0);
    land_cycle(32'hFF00_0000, 2, 1'b0, 1'b0);
    gravity(28, 14);
    // Landing exactly on the tick cycle: tick suppressed; three rows credited as 2.
    land_cycle(32'hFFF0_0000, 2, 1'b0, 1'b0);
    land_cycle(32'h0000_000F, 1, 1'b0, 1'b0);
    chk("lines_nine", 32'(lines_o), 32'd9);

    // Asynchronous reset mid-MOVE, asserted and released between edges.
    step(); step();
    #2 restart_n = 1'b0;
    #1 chk_reset_vals("async");
    #1 restart_n = 1'b1;
    lfsr_m    = 8'hA5;
    exp_lines = 0;
    start_game();
    chk("restart_piece_const", 32'(curr_piece_o), 32'd1);

    // Error in 1st GEN cycle ignored; error in 2nd GEN cycle -> OVER.
    land_cycle(32'hFF00_0000, 2, 1'b1, 1'b0);
    land_cycle(32'h0000_0000, 0, 1'b0, 1'b1);
    step(); chk("over_hold", 32'(state_o), 32'd5);
    chk("over_lines", 32'(lines_o), 32'd2);
    start_i = 1'b1;
    step(); chk("over_exit", 32'(state_o), 32'd4);
    chk("over_exit_lines", 32'(lines_o), 32'd0);
    chk("over_exit_flag", 32'(game_over_o), 32'd0);
    exp_lines = 0;

    // Saturation: 127 double clears -> 254, one more -> 255, level 7, P = 4.
    start_game();
    for (int k = 0; k < 127; k++) land_cycle(32'hFF00_0000, 2, 1'b0, 1'b0);
    chk("lines_254", 32'(lines_o), 32'd254);
    land_cycle(32'hFF00_0000, 2, 1'b0, 1'b0);
    chk("lines_255", 32'(lines_o), 32'd255);
    chk("level_7", 32'(level_o), 32'd7);
    gravity(8, 4);
    land_cycle(32'hFF00_0000, 2, 1'b0, 1'b0);
    chk("lines_sat", 32'(lines_o), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
